// File: rtl/uart_app_pkg.sv
// Shared definitions for the UART stream controller: FSM state encoding,
// control character codes and echo transform selectors.
package uart_app_pkg;

    typedef enum logic [4:0] {
        S_INIT    = 5'd0,
        S_B_CHK   = 5'd1,
        S_B_STB   = 5'd2,
        S_B_NXT   = 5'd3,
        S_CR      = 5'd4,
        S_CR_STB  = 5'd5,
        S_CR_NXT  = 5'd6,
        S_LF      = 5'd7,
        S_LF_STB  = 5'd8,
        S_LF_NXT  = 5'd9,
        S_B_REP   = 5'd10,
        S_E_WAIT  = 5'd11,
        S_E_RD    = 5'd12,
        S_E_CAP   = 5'd13,
        S_E_CHK   = 5'd14,
        S_E_STB   = 5'd15,
        S_E_END   = 5'd16
    } state_t;

    localparam int CHAR_CR    = 13;
    localparam int CHAR_LF    = 10;

    localparam int ECHO_RAW   = 0;
    localparam int ECHO_UPPER = 1;
    localparam int ECHO_INV   = 2;

endpackage

// File: rtl/uart_stream_ctrl_if.sv
// Signal bundle between the stream controller and the jtag_uart.
// The master side is the controller; the slave side is the UART.
interface uart_stream_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              uart_nwr_o;
    logic [DATA_W-1:0] uart_data_o;
    logic              uart_rd_o;
    logic [DATA_W-1:0] uart_data_i;
    logic              uart_txfl_i;
    logic              uart_rxmt_i;

    modport master (
        output uart_nwr_o,
        output uart_data_o,
        output uart_rd_o,
        input  uart_data_i,
        input  uart_txfl_i,
        input  uart_rxmt_i
    );

    modport slave (
        input  uart_nwr_o,
        input  uart_data_o,
        input  uart_rd_o,
        output uart_data_i,
        output uart_txfl_i,
        output uart_rxmt_i
    );
endinterface

// File: rtl/uart_char_xform.sv
// Combinational transform applied to echoed characters: pass-through,
// lowercase-to-uppercase, or bitwise inversion.
module uart_char_xform
    import uart_app_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ECHO_MODE = 0
) (
    input  logic [DATA_W-1:0] char_i,
    output logic [DATA_W-1:0] char_o
);

    localparam logic [DATA_W-1:0] LOW_A = DATA_W'(97);
    localparam logic [DATA_W-1:0] LOW_Z = DATA_W'(122);
    localparam logic [DATA_W-1:0] CASE_OFS = DATA_W'(32);

    always_comb begin
        char_o = char_i;
        case (ECHO_MODE)
            ECHO_RAW:   char_o = char_i;
            ECHO_UPPER: begin
                if (char_i >= LOW_A && char_i <= LOW_Z) begin
                    char_o = char_i - CASE_OFS;
                end
            end
            ECHO_INV:   char_o = ~char_i;
            default:    char_o = char_i;
        endcase
    end

endmodule

// File: rtl/uart_stream_ctrl.sv
// Application controller for jtag_uart: sends a character banner after reset,
// then echoes received characters, respecting TX-full and RX-empty flow control.
module uart_stream_ctrl
    import uart_app_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FIRST_CHAR  = 65,
    parameter int LAST_CHAR   = 90,
    parameter int BANNER_REPS = 1,
    parameter int CRLF_EN     = 1,
    parameter int ECHO_MODE   = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             restart_i,
    uart_stream_ctrl_if.master jtag,
    output logic             banner_done_o,
    output logic [CNT_W-1:0] tx_count_o,
    output logic [CNT_W-1:0] rx_count_o
);

    localparam logic [DATA_W-1:0] FIRST_V = DATA_W'(FIRST_CHAR);
    localparam logic [DATA_W-1:0] LAST_V  = DATA_W'(LAST_CHAR);
    localparam logic [DATA_W-1:0] CR_V    = DATA_W'(CHAR_CR);
    localparam logic [DATA_W-1:0] LF_V    = DATA_W'(CHAR_LF);
    localparam logic [15:0]       REPS_V  = 16'(BANNER_REPS);

    state_t state, state_nxt;

    logic [DATA_W-1:0] char_q, char_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       rep_q, rep_d;
    logic [CNT_W-1:0]  tx_q, tx_d;
    logic [CNT_W-1:0]  rx_q, rx_d;
    logic              nwr_q, nwr_d;
    logic              rd_q, rd_d;
    logic              done_q, done_d;
    logic              pend_q, pend_d;
    logic              ret_echo_q, ret_echo_d;
    logic              cr_q, cr_d;
    logic [DATA_W-1:0] xf_data;
    logic [15:0]       rep_inc;

    assign rep_inc = rep_q + 16'd1;

    uart_char_xform #(
        .DATA_W    (DATA_W),
        .ECHO_MODE (ECHO_MODE)
    ) u_xform (
        .char_i (jtag.uart_data_i),
        .char_o (xf_data)
    );

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   state_nxt = (BANNER_REPS == 0) ? S_E_WAIT : S_B_CHK;
            S_B_CHK:  if (!jtag.uart_txfl_i) state_nxt = S_B_STB;
            S_B_STB:  state_nxt = S_B_NXT;
            S_B_NXT: begin
                if (char_q < LAST_V)   state_nxt = S_B_CHK;
                else if (CRLF_EN != 0) state_nxt = S_CR;
                else                   state_nxt = S_B_REP;
            end
            S_CR:     if (!jtag.uart_txfl_i) state_nxt = S_CR_STB;
            S_CR_STB: state_nxt = S_CR_NXT;
            S_CR_NXT: state_nxt = S_LF;
            S_LF:     if (!jtag.uart_txfl_i) state_nxt = S_LF_STB;
            S_LF_STB: state_nxt = S_LF_NXT;
            S_LF_NXT: state_nxt = ret_echo_q ? S_E_WAIT : S_B_REP;
            S_B_REP:  state_nxt = (rep_inc < REPS_V) ? S_B_CHK : S_E_WAIT;
            // A pending restart outranks a waiting RX character
            S_E_WAIT: begin
                if (pend_q)                   state_nxt = S_INIT;
                else if (!jtag.uart_rxmt_i)   state_nxt = S_E_RD;
            end
            S_E_RD:   state_nxt = S_E_CAP;
            S_E_CAP:  state_nxt = S_E_CHK;
            S_E_CHK:  if (!jtag.uart_txfl_i) state_nxt = S_E_STB;
            S_E_STB:  state_nxt = S_E_END;
            S_E_END:  state_nxt = ((CRLF_EN != 0) && cr_q) ? S_LF : S_E_WAIT;
            default:  state_nxt = S_INIT;
        endcase
    end

    // Data is loaded when leaving a check state, so it is already stable the
    // cycle before the strobe and is held through the cycle after it.
    always_comb begin
        char_d     = char_q;
        data_d     = data_q;
        rep_d      = rep_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        nwr_d      = 1'b1;
        rd_d       = 1'b0;
        done_d     = done_q;
        pend_d     = pend_q | restart_i;
        ret_echo_d = ret_echo_q;
        cr_d       = cr_q;
        case (state)
            S_INIT: begin
                char_d     = FIRST_V;
                rep_d      = 16'd0;
                ret_echo_d = 1'b0;
                if (BANNER_REPS == 0) done_d = 1'b1;
            end
            S_B_CHK:  if (!jtag.uart_txfl_i) data_d = char_q;
            S_B_STB: begin
                nwr_d = 1'b0;
                tx_d  = tx_q + CNT_W'(1);
            end
            S_B_NXT: begin
                if (char_q < LAST_V) char_d = char_q + DATA_W'(1);
                else                 ret_echo_d = 1'b0;
            end
            S_CR:     if (!jtag.uart_txfl_i) data_d = CR_V;
            S_CR_STB: begin
                nwr_d = 1'b0;
                tx_d  = tx_q + CNT_W'(1);
            end
            S_LF:     if (!jtag.uart_txfl_i) data_d = LF_V;
            S_LF_STB: begin
                nwr_d = 1'b0;
                tx_d  = tx_q + CNT_W'(1);
            end
            S_B_REP: begin
                rep_d = rep_inc;
                if (rep_inc < REPS_V) char_d = FIRST_V;
                else                  done_d = 1'b1;
            end
            S_E_WAIT: begin
                if (pend_q) begin
                    done_d = 1'b0;
                    pend_d = restart_i;
                end else if (!jtag.uart_rxmt_i) begin
                    rd_d = 1'b1;
                end
            end
            S_E_CAP: begin
                data_d = xf_data;
                cr_d   = (jtag.uart_data_i == CR_V);
                rx_d   = rx_q + CNT_W'(1);
            end
            S_E_STB: begin
                nwr_d = 1'b0;
                tx_d  = tx_q + CNT_W'(1);
            end
            S_E_END:  if ((CRLF_EN != 0) && cr_q) ret_echo_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            char_q     <= FIRST_V;
            data_q     <= '0;
            rep_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            nwr_q      <= 1'b1;
            rd_q       <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            ret_echo_q <= 1'b0;
            cr_q       <= 1'b0;
        end else begin
            char_q     <= char_d;
            data_q     <= data_d;
            rep_q      <= rep_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            nwr_q      <= nwr_d;
            rd_q       <= rd_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            ret_echo_q <= ret_echo_d;
            cr_q       <= cr_d;
        end
    end

    assign jtag.uart_nwr_o  = nwr_q;
    assign jtag.uart_data_o = data_q;
    assign jtag.uart_rd_o   = rd_q;
    assign banner_done_o    = done_q;
    assign tx_count_o       = tx_q;
    assign rx_count_o       = rx_q;

endmodule

// File: tb/tb_uart_stream_ctrl.sv
// Directed bench for uart_stream_ctrl: banner, flow control, echo transforms,
// restart handling, mid-strobe reset and a banner-less configuration.
module tb_uart_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nreset_a, nreset_b;
    logic        restart_a, restart_b;
    logic        done_a, done_b;
    logic [15:0] txc_a, rxc_a, txc_b, rxc_b;

    uart_stream_ctrl_if #(.DATA_W(8)) ifa ();
    uart_stream_ctrl_if #(.DATA_W(8)) ifb ();

    uart_stream_ctrl #(
        .DATA_W(8), .FIRST_CHAR(65), .LAST_CHAR(90), .BANNER_REPS(1),
        .CRLF_EN(1), .ECHO_MODE(1), .CNT_W(16)
    ) dut_a (
        .clk_i(clk), .nreset_i(nreset_a), .restart_i(restart_a), .jtag(ifa),
        .banner_done_o(done_a), .tx_count_o(txc_a), .rx_count_o(rxc_a)
    );

    uart_stream_ctrl #(
        .DATA_W(8), .FIRST_CHAR(65), .LAST_CHAR(90), .BANNER_REPS(0),
        .CRLF_EN(1), .ECHO_MODE(2), .CNT_W(16)
    ) dut_b (
        .clk_i(clk), .nreset_i(nreset_b), .restart_i(restart_b), .jtag(ifb),
        .banner_done_o(done_b), .tx_count_o(txc_b), .rx_count_o(rxc_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [7:0] txq_a[$];
    int         tcyc_a[$];
    logic [7:0] txq_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifa.uart_nwr_o === 1'b0) begin
            txq_a.push_back(ifa.uart_data_o);
            tcyc_a.push_back(cyc);
        end
        if (ifb.uart_nwr_o === 1'b0) txq_b.push_back(ifb.uart_data_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_tx_a(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && txq_a.size() < n; i++) tick();
        check(tag, 32'(txq_a.size() >= n), 32'd1);
    endtask

    task automatic wait_rd_a(input string tag, input int budget);
        for (int i = 0; i < budget && ifa.uart_rd_o !== 1'b1; i++) tick();
        check(tag, 32'(ifa.uart_rd_o), 32'd1);
    endtask

    initial begin
        int bad;
        int s;
        nreset_a = 1'b0; nreset_b = 1'b0;
        restart_a = 1'b0; restart_b = 1'b0;
        ifa.uart_data_i = 8'h00; ifa.uart_txfl_i = 1'b0; ifa.uart_rxmt_i = 1'b1;
        ifb.uart_data_i = 8'h00; ifb.uart_txfl_i = 1'b0; ifb.uart_rxmt_i = 1'b1;
        repeat (3) tick();

        check("rst_nwr",  32'(ifa.uart_nwr_o),  32'd1);
        check("rst_rd",   32'(ifa.uart_rd_o),   32'd0);
        check("rst_data", 32'(ifa.uart_data_o), 32'd0);
        check("rst_done", 32'(done_a),          32'd0);
        check("rst_txc",  32'(txc_a),           32'd0);
        check("rst_rxc",  32'(rxc_a),           32'd0);

        // Banner with a TX-full stall after character 70
        nreset_a = 1'b1;
        wait_tx_a("wait_70", 6, 100);
        ifa.uart_txfl_i = 1'b1;
        repeat (20) tick();
        check("full_no_strobe", 32'(txq_a.size()), 32'd6);
        check("full_txc",       32'(txc_a),        32'd6);
        ifa.uart_txfl_i = 1'b0;
        wait_tx_a("wait_banner", 28, 200);
        for (int i = 0; i < 26; i++)
            check($sformatf("banner_%0d", i), 32'(txq_a[i]), 32'(65 + i));
        check("banner_cr", 32'(txq_a[26]), 32'd13);
        check("banner_lf", 32'(txq_a[27]), 32'd10);
        bad = 0;
        for (int i = 1; i < 28; i++)
            if (i != 6 && tcyc_a[i] - tcyc_a[i-1] != 3) bad++;
        check("banner_spacing", 32'(bad), 32'd0);
        repeat (3) tick();
        check("banner_done", 32'(done_a), 32'd1);
        check("banner_txc",  32'(txc_a),  32'd28);

        // Echo with uppercase transform, then CR expanding to CR LF
        ifa.uart_data_i = 8'd97; ifa.uart_rxmt_i = 1'b0;
        wait_rd_a("rd_a", 20);
        ifa.uart_rxmt_i = 1'b1;
        wait_tx_a("wait_echo_a", 29, 30);
        check("echo_a_upper", 32'(txq_a[28]), 32'd65);
        ifa.uart_data_i = 8'd13; ifa.uart_rxmt_i = 1'b0;
        wait_rd_a("rd_cr", 20);
        ifa.uart_rxmt_i = 1'b1;
        wait_tx_a("wait_echo_crlf", 31, 40);
        check("echo_cr", 32'(txq_a[29]), 32'd13);
        check("echo_lf", 32'(txq_a[30]), 32'd10);
        repeat (3) tick();
        check("echo_rxc", 32'(rxc_a), 32'd2);
        check("echo_txc", 32'(txc_a), 32'd31);

        // Restart from idle, then a second restart mid-banner
        restart_a = 1'b1; tick(); restart_a = 1'b0;
        wait_tx_a("wait_replay1", 32, 40);
        check("replay1_first", 32'(txq_a[31]), 32'd65);
        check("replay1_done_clr", 32'(done_a), 32'd0);
        wait_tx_a("wait_mid", 41, 60);
        restart_a = 1'b1; tick(); restart_a = 1'b0;
        wait_tx_a("wait_replay2", 87, 400);
        check("replay1_lf",   32'(txq_a[58]), 32'd10);
        check("replay2_first", 32'(txq_a[59]), 32'd65);
        check("replay2_lf",   32'(txq_a[86]), 32'd10);
        repeat (3) tick();
        check("replay2_done", 32'(done_a), 32'd1);
        check("replay2_count", 32'(txq_a.size()), 32'd87);

        // Restart during an echo: echo finishes, then the banner replays
        ifa.uart_data_i = 8'd98; ifa.uart_rxmt_i = 1'b0;
        wait_rd_a("rd_b", 20);
        ifa.uart_rxmt_i = 1'b1;
        restart_a = 1'b1; tick(); restart_a = 1'b0;
        wait_tx_a("wait_echo_restart", 89, 40);
        check("echo_b_upper",  32'(txq_a[87]), 32'd66);
        check("replay3_first", 32'(txq_a[88]), 32'd65);

        // Reset landing on the launch cycle of character 70
        wait_tx_a("wait_69", 93, 40);
        check("pre_rst_69", 32'(txq_a[92]), 32'd69);
        tick(); tick();
        check("stb_data", 32'(ifa.uart_data_o), 32'd70);
        check("stb_nwr",  32'(ifa.uart_nwr_o),  32'd1);
        nreset_a = 1'b0;
        tick();
        check("mid_rst_nwr",  32'(ifa.uart_nwr_o), 32'd1);
        check("mid_rst_rd",   32'(ifa.uart_rd_o),  32'd0);
        check("mid_rst_txc",  32'(txc_a),          32'd0);
        check("mid_rst_rxc",  32'(rxc_a),          32'd0);
        check("mid_rst_done", 32'(done_a),         32'd0);
        check("mid_rst_nostb", 32'(txq_a.size()),  32'd93);
        nreset_a = 1'b1;
        s = txq_a.size();
        wait_tx_a("wait_post_rst", s + 1, 20);
        check("post_rst_first", 32'(txq_a[s]), 32'd65);
        check("post_rst_txc",   32'(txc_a),    32'd1);

        // Banner-less instance with inverting echo
        check("b_rst_done", 32'(done_b), 32'd0);
        nreset_b = 1'b1;
        tick(); tick();
        check("b_done", 32'(done_b), 32'd1);
        check("b_no_banner", 32'(txq_b.size()), 32'd0);
        ifb.uart_data_i = 8'h0F; ifb.uart_rxmt_i = 1'b0;
        for (int i = 0; i < 20 && ifb.uart_rd_o !== 1'b1; i++) tick();
        check("b_rd", 32'(ifb.uart_rd_o), 32'd1);
        ifb.uart_rxmt_i = 1'b1;
        for (int i = 0; i < 30 && txq_b.size() < 1; i++) tick();
        check("b_echo_count", 32'(txq_b.size()), 32'd1);
        if (txq_b.size() > 0) check("b_echo_inv", 32'(txq_b[0]), 32'hF0);
        repeat (3) tick();
        check("b_txc", 32'(txc_b), 32'd1);
        check("b_rxc", 32'(rxc_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
